program_loader: RTL
===================

// Module: program_loader
// PURPOSE
// - Upstream neighbour of the instruction fetch stage. Receives a byte stream and assembles 24-bit instructions,
//   three bytes per instruction, MSB first. Writes each one into instruction memory through a single write port.
// - Holds the CPU (cpu_hold) from load start until the load completes, so the core never fetches a partial program.
// PARAMETERS
// - ADDR_W  5  instruction memory address width; depth = 2**ADDR_W instructions (32)
// PORTS
// - CLK          in   1       clock, all state changes on rising edge
// - reset        in   1       asynchronous, active-high reset
// - load_start   in   1       1-cycle request to begin a load; sampled only in IDLE or ERROR
// - byte_valid   in   1       source has byte_data available
// - byte_data    in   8       stream byte
// - byte_ready   out  1       loader accepts byte this cycle; transfer = byte_valid & byte_ready
// - im_we        out  1       instruction memory write strobe, 1 cycle per instruction
// - im_addr      out  ADDR_W  write address
// - im_wdata     out  24      instruction word {byte0,byte1,byte2}
// - cpu_hold     out  1       high while loading; core reset/stall qualifier
// - load_done    out  1       1-cycle pulse on successful completion
// - load_error   out  1       level; set on error, cleared by load_start or reset
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=0,
//   load_done=0, load_error=0; byte counter, instruction counter and count register cleared.
// - States: IDLE, COUNT, DATA, WRITE, CHECK (only with the checksum macro), DONE, ERROR.
// - IDLE: byte_ready=0. load_start=1 -> COUNT and clear load_error. load_start in any other state is ignored.
// - cpu_hold=1 in COUNT, DATA, WRITE, CHECK, DONE and ERROR; cpu_hold=0 only in IDLE.
// - COUNT: byte_ready=1. Accepted byte = N, the instruction count.
//   - N > 2**ADDR_W -> ERROR.
//   - N = 0 -> DONE, or CHECK with the checksum macro.
//   - else -> DATA with byte index 0 and im_addr 0.
// - DATA: byte_ready=1. Bytes are shifted into im_wdata MSB first, index 0 -> 1 -> 2.
//   Acceptance of the third byte -> WRITE in the next cycle. Gaps (byte_valid=0) stall with no state change.
// - WRITE: exactly one cycle. im_we=1 with the current im_addr/im_wdata; byte_ready=0 (the source holds any
//   pending byte). Next state:
//   - instructions written < N -> DATA, im_addr+1, byte index 0.
//   - last instruction -> DONE, or CHECK with the checksum macro.
// - im_addr never wraps: N <= 2**ADDR_W, so the maximum address written is 2**ADDR_W-1.
// - im_wdata and im_addr hold their values outside WRITE; im_we=0 outside WRITE.
// - DONE: one cycle, load_done=1, byte_ready=0 -> IDLE. cpu_hold falls on the transition to IDLE.
// - ERROR: load_error=1, cpu_hold=1, byte_ready=0. Stays until load_start (-> COUNT) or reset.
// - Latency: im_we is asserted the cycle after the third byte of the instruction is accepted.
// - Reset mid-load: immediate return to reset values. Memory contents already written are not undone.
//   cpu_hold drops, so the software/bench must reload.
// CONFIGURATION
// - PROGLOAD_CHECKSUM_EN defined:
//   - A running XOR of every accepted byte (count and data) is kept.
//   - After the last WRITE, or directly after COUNT when N=0, the FSM enters CHECK with byte_ready=1.
//   - One checksum byte is accepted: match with the running XOR -> DONE; mismatch -> ERROR.
// - Not defined: no CHECK state and no XOR register. The FSM goes straight to DONE, and the stream byte that
//   follows the last instruction is not consumed (byte_ready=0).
// TESTING
// - Reset, load_start, N=2, bytes 12 34 56 AB CD EF
//   -> im_we at addr 0 data 0x123456, then addr 1 data 0xABCDEF; load_done 1 cycle; cpu_hold 1->0 after DONE.
// - Same stream with byte_valid low 1-3 random cycles between bytes -> identical writes.
//   byte_ready=0 in each WRITE cycle; no byte is lost or duplicated.
// - N=0 -> no im_we; load_done pulses 1 cycle after count accept (no macro); load_error=0.
// - N=33 (ADDR_W=5) -> ERROR: load_error=1, cpu_hold=1, byte_ready=0.
//   Then load_start with N=1, bytes 00 00 01 -> load_error clears, addr 0 gets 0x000001.
// - reset pulsed after 4 data bytes accepted -> all outputs at reset values within the same cycle;
//   no im_we afterwards; IDLE.
// - With PROGLOAD_CHECKSUM_EN: N=1, bytes 01 02 03, checksum 01 -> load_done.
//   Same stream with checksum 00 -> load_error=1 and cpu_hold stays 1.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 24-bit instructions (MSB first) into instruction memory
// while holding the CPU. Optional trailing XOR checksum enabled by `define PROGLOAD_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [23:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;
`ifdef PROGLOAD_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_END   = S_CHECK;
`else
  localparam logic [2:0] S_END   = S_DONE;
`endif

  // Largest legal instruction count; the count byte is compared as 9 bits so 2**ADDR_W fits.
  localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

  logic [2:0]        state;
  logic [1:0]        byte_idx;
  logic [15:0]       shift;
  logic [ADDR_W:0]   count_n;
  logic              accept;
  logic              last_instr;
`ifdef PROGLOAD_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept     = byte_valid & byte_ready;
  assign last_instr = ({1'b0, im_addr} == (count_n - (ADDR_W+1)'(1)));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_idx <= 2'd0;
      shift    <= 16'd0;
      count_n  <= '0;
      im_addr  <= '0;
      im_wdata <= 24'd0;
`ifdef PROGLOAD_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start) state <= S_COUNT;
        end
        S_COUNT: begin
          if (accept) begin
`ifdef PROGLOAD_CHECKSUM_EN
            csum <= byte_data;
`endif
            count_n <= byte_data[ADDR_W:0];
            if ({1'b0, byte_data} > DEPTH) begin
              state <= S_ERROR;
            end else if (byte_data == 8'd0) begin
              state <= S_END;
            end else begin
              state    <= S_DATA;
              byte_idx <= 2'd0;
              im_addr  <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
`ifdef PROGLOAD_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            // The word register only changes on entry to WRITE, so it stays stable between writes.
            if (byte_idx == 2'd2) begin
              im_wdata <= {shift, byte_data};
              byte_idx <= 2'd0;
              state    <= S_WRITE;
            end else begin
              shift    <= {shift[7:0], byte_data};
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          if (last_instr) begin
            state <= S_END;
          end else begin
            im_addr  <= im_addr + ADDR_W'(1);
            byte_idx <= 2'd0;
            state    <= S_DATA;
          end
        end
`ifdef PROGLOAD_CHECKSUM_EN
        S_CHECK: begin
          if (accept) state <= (byte_data == csum) ? S_DONE : S_ERROR;
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        S_ERROR: begin
          if (load_start) state <= S_COUNT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // All handshake/status outputs decode directly from state, so an async reset clears them at once.
`ifdef PROGLOAD_CHECKSUM_EN
  assign byte_ready = (state == S_COUNT) | (state == S_DATA) | (state == S_CHECK);
`else
  assign byte_ready = (state == S_COUNT) | (state == S_DATA);
`endif
  assign im_we      = (state == S_WRITE);
  assign cpu_hold   = (state != S_IDLE);
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);

endmodule
